// File: rtl/matrix_result_streamer_pkg.sv
// Shared definitions for the matrix result streamer: word width, FSM states,
// and the flat-bus bit offset of element (r,c).
package matrix_result_streamer_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic int elem_lsb(input int r, input int c, input int n);
    return (r * n + c) * WORD_W;
  endfunction

endpackage

// File: rtl/matrix_result_streamer_rowcol_counter.sv
// Row-major (row, col) walker over an n x n matrix; at_last flags the final cell.
module rowcol_counter #(
  parameter  int n   = 4,
  localparam int RCW = (n > 1) ? $clog2(n) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           advance,
  output logic [RCW-1:0] row,
  output logic [RCW-1:0] col,
  output logic           at_last
);

  localparam logic [RCW-1:0] LAST_IDX = RCW'(n - 1);

  logic [RCW-1:0] r_row;
  logic [RCW-1:0] r_col;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (advance) begin
      if (r_col == LAST_IDX) begin
        r_col <= '0;
        r_row <= (r_row == LAST_IDX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign row     = r_row;
  assign col     = r_col;
  assign at_last = (r_row == LAST_IDX) && (r_col == LAST_IDX);

endmodule

// File: rtl/matrix_result_streamer.sv
// Captures a level-held n x n result matrix into a shadow register and streams
// it out element by element (row-major) over a valid/ready handshake.
module matrix_result_streamer
  import matrix_result_streamer_pkg::*;
#(
  parameter  int n   = 4,
  localparam int RCW = (n > 1) ? $clog2(n) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_W*n*n:0]   matrix_in,
  input  logic                  in_ready,
  input  logic                  enable,
  output logic [WORD_W-1:0]     m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [RCW-1:0]        m_row,
  output logic [RCW-1:0]        m_col,
  output logic                  busy
);

  localparam int FLAT_W = WORD_W * n * n;
  localparam int NELEM  = n * n;
  localparam int IDXW   = (NELEM > 1) ? $clog2(NELEM) : 1;

  state_t              r_state;
  state_t              w_state_next;
  logic                w_capture;
  logic                w_xfer;
  logic                w_at_last;
  logic [RCW-1:0]      w_row;
  logic [RCW-1:0]      w_col;
  logic [IDXW-1:0]     w_idx;
  logic [FLAT_W-1:0]   r_shadow;
  logic [WORD_W-1:0]   w_words [NELEM];
  logic                w_unused_top;

  // The extra top bit of the input bus carries no data.
  assign w_unused_top = matrix_in[FLAT_W];

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_xfer       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_ready && enable) begin
          w_capture    = 1'b1;
          w_state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        w_xfer = m_ready;
        if (m_ready && w_at_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        // Hold here until the controller drops its level so one result streams once.
        if (!in_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset)          r_shadow <= '0;
    else if (w_capture) r_shadow <= matrix_in[FLAT_W-1:0];
  end

  rowcol_counter #(.n(n)) u_rowcol (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_capture),
    .advance (w_xfer),
    .row     (w_row),
    .col     (w_col),
    .at_last (w_at_last)
  );

  for (genvar gi = 0; gi < NELEM; gi++) begin : g_words
    assign w_words[gi] = r_shadow[elem_lsb(gi / n, gi % n, n) +: WORD_W];
  end

  assign w_idx = IDXW'(w_row) * IDXW'(n) + IDXW'(w_col);

  assign m_valid = (r_state == ST_STREAM);
  assign m_data  = m_valid ? w_words[w_idx] : '0;
  assign m_last  = m_valid && w_at_last;
  assign m_row   = w_row;
  assign m_col   = w_col;
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed bench for matrix_result_streamer (n=2 main instance, n=1 corner instance)
// with a queue scoreboard of expected (data,row,col,last) beats.
module tb_matrix_result_streamer;

  logic         clk = 1'b0;
  logic         reset;
  logic [128:0] matrix_in;
  logic         in_ready, enable, m_ready;
  logic [31:0]  m_data;
  logic         m_valid, m_last, busy;
  logic [0:0]   m_row, m_col;

  logic [32:0]  mi1;
  logic         in1, en1, mr1;
  logic [31:0]  data1;
  logic         valid1, last1, busy1;
  logic [0:0]   row1, col1;

  typedef struct packed {
    logic [31:0] d;
    logic        r;
    logic        c;
    logic        l;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] cur_mat [4];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  matrix_result_streamer #(.n(2)) u_dut (
    .clk(clk), .reset(reset), .matrix_in(matrix_in), .in_ready(in_ready),
    .enable(enable), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .m_row(m_row), .m_col(m_col), .busy(busy)
  );

  matrix_result_streamer #(.n(1)) u_dut1 (
    .clk(clk), .reset(reset), .matrix_in(mi1), .in_ready(in1),
    .enable(en1), .m_data(data1), .m_valid(valid1), .m_ready(mr1),
    .m_last(last1), .m_row(row1), .m_col(col1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_mat(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d);
    cur_mat[0] = a; cur_mat[1] = b; cur_mat[2] = c; cur_mat[3] = d;
    matrix_in = {1'b1, d, c, b, a};
  endtask

  task automatic push_all();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.d = cur_mat[i];
      e.r = 1'(i / 2);
      e.c = 1'(i % 2);
      e.l = (i == 3);
      sb_q.push_back(e);
    end
  endtask

  // Check the current beat against the scoreboard front, then advance one clock.
  task automatic clk_step();
    exp_t e;
    if (m_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q[0];
        chk("m_data", m_data, e.d);
        chk("m_row", 32'(m_row), 32'(e.r));
        chk("m_col", 32'(m_col), 32'(e.c));
        chk("m_last", 32'(m_last), 32'(e.l));
        $display("[TB] beat data=%0h row=%0d col=%0d last=%0b ready=%0b",
                 m_data, m_row, m_col, m_last, m_ready);
        if (m_ready) void'(sb_q.pop_front());
      end
    end else begin
      chk("last_without_valid", 32'(m_last), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    reset = 1'b1; in_ready = 1'b0; enable = 1'b0; m_ready = 1'b0;
    mi1 = '0; in1 = 1'b0; en1 = 1'b0; mr1 = 1'b0;
    drive_mat(32'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_row", 32'(m_row), 32'd0);

    // Basic stream, full-rate ready, input changed after capture.
    reset = 1'b0; enable = 1'b1; in_ready = 1'b1; m_ready = 1'b1;
    drive_mat(32'd1, 32'd0, 32'd1, 32'd1);
    push_all();
    clk_step();
    chk("cap_valid", 32'(m_valid), 32'd1);
    chk("cap_busy", 32'(busy), 32'd1);
    drive_mat(32'd9, 32'd9, 32'd9, 32'd9);
    repeat (4) clk_step();
    chk("stream1_drained", 32'(sb_q.size()), 32'd0);
    chk("done_valid", 32'(m_valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);

    // Level-held in_ready must not restart the stream.
    repeat (3) begin
      clk_step();
      chk("hold_no_valid", 32'(m_valid), 32'd0);
    end
    in_ready = 1'b0;
    clk_step();
    chk("idle_busy", 32'(busy), 32'd0);

    // Second stream with stalling ready pattern.
    drive_mat(32'd5, 32'd6, 32'd7, 32'd8);
    in_ready = 1'b1; m_ready = 1'b0;
    push_all();
    clk_step();
    chk("cap2_valid", 32'(m_valid), 32'd1);
    drive_mat(32'd9, 32'd9, 32'd9, 32'd9);
    for (int i = 0; i < 7; i++) begin
      m_ready = pat[i];
      clk_step();
    end
    chk("stall_drained", 32'(sb_q.size()), 32'd0);
    chk("stall_done_valid", 32'(m_valid), 32'd0);

    // Reset in the middle of a stream.
    in_ready = 1'b0;
    clk_step();
    drive_mat(32'h11, 32'h22, 32'h33, 32'h44);
    in_ready = 1'b1; m_ready = 1'b1;
    push_all();
    clk_step();
    repeat (2) clk_step();
    m_ready = 1'b0; reset = 1'b1;
    clk_step();
    chk("midrst_valid", 32'(m_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_data", m_data, 32'd0);
    sb_q.delete();
    reset = 1'b0;
    drive_mat(32'hA, 32'hB, 32'hC, 32'hD);
    push_all();
    clk_step();
    chk("recap_valid", 32'(m_valid), 32'd1);
    chk("recap_row", 32'(m_row), 32'd0);
    chk("recap_col", 32'(m_col), 32'd0);
    m_ready = 1'b1;
    repeat (4) clk_step();
    chk("recap_drained", 32'(sb_q.size()), 32'd0);

    // enable low blocks capture.
    in_ready = 1'b0;
    clk_step();
    enable = 1'b0; in_ready = 1'b1;
    drive_mat(32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003);
    repeat (5) begin
      clk_step();
      chk("en_low_no_valid", 32'(m_valid), 32'd0);
    end
    enable = 1'b1;
    push_all();
    clk_step();
    chk("en_cap_valid", 32'(m_valid), 32'd1);
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      clk_step();
    end
    chk("rand_drained", 32'(sb_q.size()), 32'd0);
    chk("rand_done_valid", 32'(m_valid), 32'd0);

    // n = 1 corner case: one beat carrying m_last, then DONE.
    mi1 = {1'b1, 32'hABCD1234}; in1 = 1'b1; en1 = 1'b1; mr1 = 1'b1;
    @(posedge clk); #1;
    chk("n1_valid", 32'(valid1), 32'd1);
    chk("n1_last", 32'(last1), 32'd1);
    chk("n1_data", data1, 32'hABCD1234);
    $display("[TB] n1 beat data=%0h last=%0b", data1, last1);
    @(posedge clk); #1;
    chk("n1_done_valid", 32'(valid1), 32'd0);
    chk("n1_done_busy", 32'(busy1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_result_streamer.md
MATRIX_RESULT_STREAMER -- requirements
Module: matrix_result_streamer

Interface
REQ-001 Parameter n, default 4: matrix dimension (n x n, 32-bit unsigned elements).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 matrix_in  input  32*n*n+1  flat result matrix; element (r,c) occupies bits [(r*n+c)*32+31 : (r*n+c)*32]; top bit ignored.
REQ-005 in_ready  input  1  result-valid level from the multiply controller; held high while the result is stable.
REQ-006 enable  input  1  arms capture; low blocks new captures only.
REQ-007 m_data  output  32  current element.
REQ-008 m_valid  output  1  m_data valid.
REQ-009 m_ready  input  1  downstream accepts; a transfer occurs on a cycle with m_valid and m_ready both high.
REQ-010 m_last  output  1  high with the final element (index n*n-1).
REQ-011 m_row, m_col  output  $clog2(n) each (min 1)  coordinates of the current element.
REQ-012 busy  output  1  high in STREAM or DONE.

Function
REQ-013 FSM states: IDLE, STREAM, DONE.
REQ-014 IDLE: if in_ready and enable at posedge, copy matrix_in into an internal shadow register, set row=col=0, go to STREAM.
REQ-015 m_valid rises the cycle after the capture edge (1-cycle latency); no combinational path from in_ready to m_valid.
REQ-016 STREAM: m_valid=1; m_data = shadow element (m_row,m_col); data and coordinates hold while m_ready is low.
REQ-017 On each transfer: col increments; at col=n-1, col wraps to 0 and row increments; row-major order.
REQ-018 m_last = 1 only when row=n-1 and col=n-1 and m_valid=1.
REQ-019 Transfer with m_last: go to DONE; m_valid=0 on the next cycle.
REQ-020 DONE: wait for in_ready=0, then go to IDLE; prevents re-streaming a level-held result.
REQ-021 Changes on matrix_in or in_ready during STREAM are ignored; output comes only from the shadow copy.
REQ-022 enable low during STREAM or DONE has no effect.
REQ-023 n=1: a single transfer with m_last=1, then DONE.
REQ-024 m_ready high continuously: n*n consecutive transfers, one per cycle, no bubbles.
REQ-025 m_ready may toggle arbitrarily; no element is skipped or duplicated.

Reset
REQ-026 reset at posedge: state=IDLE, row=col=0, m_valid=0, m_last=0, busy=0, m_data=0, shadow register cleared.
REQ-027 reset mid-STREAM aborts the transfer; no further m_valid until a new capture; reset takes priority over all other inputs in that cycle.
REQ-028 The first capture is possible on the first posedge after reset deasserts.

Structure
REQ-029 Shared package holds: word width constant (32), FSM state enum, flat-bus index helper (r*n+c)*32.
REQ-030 One sub-module, rowcol_counter (parameter n; inputs clk, reset, clear, advance; outputs row, col, at_last), implements REQ-017/018.
REQ-031 The element select is a registered or combinational mux from the shadow register; no memory macro; target size 120-400 lines RTL.

Verification
REQ-032 n=2, matrix_in={1,0,1,1} (index 0..3), in_ready=1, m_ready=1 -> m_data 1,0,1,1 on 4 consecutive cycles; m_last only on the 4th; m_valid rises 1 cycle after capture.
REQ-033 n=2, m_ready pattern 1,0,0,1,1,0,1 -> exactly 4 transfers in order 1,0,1,1; data and coordinates stable during stalls.
REQ-034 in_ready held high after completion -> stays in DONE, no second stream; drop in_ready 1 cycle, raise it again -> second stream starts.
REQ-035 matrix_in changed to {9,9,9,9} after capture -> streamed values remain the captured values.
REQ-036 reset asserted after 2nd transfer -> m_valid=0 on the next cycle, busy=0; new capture restarts at (0,0).
REQ-037 enable=0 with in_ready=1 for 5 cycles -> no m_valid; enable=1 -> capture on the next edge.
